// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control / program-load block.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StRun    = 3'd2,
        StStep   = 3'd3,
        StHalted = 3'd4
    } dbg_state_e;

    typedef enum logic [2:0] {
        CmdNop      = 3'd0,
        CmdLoad     = 3'd1,
        CmdRun      = 3'd2,
        CmdHalt     = 3'd3,
        CmdStep     = 3'd4,
        CmdResetCpu = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        CauseNone  = 3'd0,
        CauseHost  = 3'd1,
        CauseBp    = 3'd2,
        CauseLimit = 3'd3,
        CauseStep  = 3'd4
    } halt_cause_e;

endpackage

// File: rtl/cpu_debug_ctrl_if.sv
// Host command port, program-load stream and instruction-memory write port.
interface cpu_debug_ctrl_if #(
    parameter int unsigned INSTR_W = 18,
    parameter int unsigned ADDR_W  = 8
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [ADDR_W-1:0]  cmd_arg;
    logic               ld_valid;
    logic               ld_ready;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, ld_last,
        input  cmd_ready, ld_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, ld_last,
        output cmd_ready, ld_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_dbg_bp_match.sv
// PC breakpoint comparator array; hit_idx reports the lowest matching slot.
module cpu_dbg_bp_match #(
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned IdxW  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic [ADDR_W-1:0]        pc,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    output logic                     hit,
    output logic [IdxW-1:0]          hit_idx
);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Scan downward so the lowest matching slot is the one left in hit_idx.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control and program-load front end for the CPU: load stream, run/halt/step,
// breakpoints, cycle-limit watchdog, halt cause and enabled-cycle counter.
module cpu_debug_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned INSTR_W = 18,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned NUM_BP  = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    cpu_debug_ctrl_if.slave          bus,
    output logic                     cpu_rst,
    output logic                     cpu_en,
    input  logic [ADDR_W-1:0]        cpu_pc,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [CNT_W-1:0]         cycle_limit,
    output logic [2:0]               state,
    output logic [2:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_count
);

    localparam int unsigned IdxW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    dbg_state_e        state_q, state_d;
    halt_cause_e       cause_q, cause_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, count_inc;
    logic              skip_q, skip_d;
    logic              cmd_ready_q, ld_ready_q, cpu_rst_q;
    logic              bp_hit, cmd_acc, limit_hit;
    logic [IdxW-1:0]   bp_idx;

    cpu_dbg_bp_match #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W)
    ) u_bp_match (
        .pc      (cpu_pc),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .hit     (bp_hit),
        .hit_idx (bp_idx)
    );

    always_comb begin : p_bp_sanity
        assert (!bp_hit || bp_en[bp_idx]);
    end

    // skip_q lets the first cycle after a resume step off a breakpointed PC.
    always_comb begin
        unique case (state_q)
            StRun:   cpu_en = !(bp_hit && !skip_q);
            StStep:  cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_comb begin
        bus.imem_we    = (state_q == StLoad) && bus.ld_valid;
        bus.imem_addr  = ptr_q;
        bus.imem_wdata = INSTR_W'(bus.ld_data);
    end

    always_comb begin
        cmd_acc   = bus.cmd_valid && cmd_ready_q;
        count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        limit_hit = cpu_en && (cycle_limit != '0) && (count_q + CNT_W'(1) == cycle_limit);

        state_d = state_q;
        cause_d = cause_q;
        ptr_d   = ptr_q;
        skip_d  = 1'b0;
        count_d = cpu_en ? count_inc : count_q;

        if (cmd_acc && bus.cmd_op == CmdResetCpu) begin
            state_d = StIdle;
            count_d = '0;
            cause_d = CauseNone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_acc && bus.cmd_op == CmdLoad) begin
                        state_d = StLoad;
                        ptr_d   = bus.cmd_arg;
                    end else if (cmd_acc && bus.cmd_op == CmdRun) begin
                        state_d = StRun;
                        count_d = '0;
                        cause_d = CauseNone;
                    end else if (cmd_acc && bus.cmd_op == CmdStep) begin
                        state_d = StStep;
                    end
                end
                StLoad: begin
                    if (bus.ld_valid && ld_ready_q) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        if (bus.ld_last) state_d = StIdle;
                    end
                end
                StRun: begin
                    if (bp_hit && !skip_q) begin
                        state_d = StHalted;
                        cause_d = CauseBp;
                    end else if (limit_hit) begin
                        state_d = StHalted;
                        cause_d = CauseLimit;
                    end else if (cmd_acc && bus.cmd_op == CmdHalt) begin
                        state_d = StHalted;
                        cause_d = CauseHost;
                    end
                end
                StStep: begin
                    state_d = StHalted;
                    cause_d = CauseStep;
                end
                StHalted: begin
                    if (cmd_acc && bus.cmd_op == CmdRun) begin
                        state_d = StRun;
                        skip_d  = 1'b1;
                    end else if (cmd_acc && bus.cmd_op == CmdStep) begin
                        state_d = StStep;
                    end else if (cmd_acc && bus.cmd_op == CmdLoad) begin
                        state_d = StLoad;
                        ptr_d   = bus.cmd_arg;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cause_q     <= CauseNone;
            ptr_q       <= '0;
            count_q     <= '0;
            skip_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            ld_ready_q  <= 1'b0;
            cpu_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            skip_q      <= skip_d;
            cmd_ready_q <= (state_d != StLoad);
            ld_ready_q  <= (state_d == StLoad);
            cpu_rst_q   <= (state_d == StIdle) || (state_d == StLoad);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.ld_ready  = ld_ready_q;
    assign cpu_rst       = cpu_rst_q;
    assign state         = state_q;
    assign halt_cause    = cause_q;
    assign cycle_count   = count_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a simple PC model driven by cpu_rst/cpu_en.
module tb_cpu_debug_ctrl;

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_RUN  = 3'd2;
    localparam logic [2:0] OP_HALT = 3'd3;
    localparam logic [2:0] OP_STEP = 3'd4;
    localparam logic [2:0] OP_RCPU = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rst, cpu_en;
    logic [7:0]  pc = 8'h00;
    logic [1:0]  bp_en;
    logic [15:0] bp_addr;
    logic [31:0] cycle_limit;
    logic [2:0]  state, halt_cause;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    cpu_debug_ctrl_if #(.INSTR_W(18), .ADDR_W(8)) bus ();

    cpu_debug_ctrl #(
        .INSTR_W (18),
        .ADDR_W  (8),
        .NUM_BP  (2),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cpu_rst     (cpu_rst),
        .cpu_en      (cpu_en),
        .cpu_pc      (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cycle_limit (cycle_limit),
        .state       (state),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_rst) pc <= 8'h00;
        else if (cpu_en) pc <= pc + 8'h01;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
    endtask

    task automatic ld_word(input string tag, input logic [17:0] d, input logic last,
                           input logic [7:0] exp_addr);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1;
        check({tag, "_we"}, 32'(bus.imem_we), 32'd1);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'(exp_addr));
        check({tag, "_data"}, 32'(bus.imem_wdata), 32'(d));
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic ld_gap(input string tag);
        bus.ld_valid = 1'b0;
        #1;
        check(tag, 32'(bus.imem_we), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_arg = 8'h00;
        bus.ld_valid = 1'b0; bus.ld_data = 18'h0; bus.ld_last = 1'b0;
        bp_en = 2'b00; bp_addr = 16'h0000; cycle_limit = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        check("rst_count", cycle_count, 32'd0);

        // HALT is not legal in IDLE and must be ignored
        send_cmd(OP_HALT, 8'h00);
        check("idle_halt_ignored", 32'(state), 32'd0);

        // Scenario 1: two-word load from address 0
        send_cmd(OP_LOAD, 8'h00);
        check("s1_state_load", 32'(state), 32'd1);
        check("s1_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("s1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("s1_cpu_rst_load", 32'(cpu_rst), 32'd1);
        ld_word("s1_w0", 18'h01123, 1'b0, 8'h00);
        ld_word("s1_w1", 18'h2120A, 1'b1, 8'h01);
        #1;
        check("s1_state_idle", 32'(state), 32'd0);
        check("s1_cpu_rst_idle", 32'(cpu_rst), 32'd1);
        check("s1_we_after", 32'(bus.imem_we), 32'd0);

        // Scenario 2: wrap from 0xFF with ld_valid gaps
        tick();
        send_cmd(OP_LOAD, 8'hFF);
        ld_gap("s2_gap0");
        ld_word("s2_w0", 18'h3FFFF, 1'b0, 8'hFF);
        ld_gap("s2_gap1");
        ld_word("s2_w1", 18'h00001, 1'b0, 8'h00);
        ld_gap("s2_gap2");
        ld_gap("s2_gap3");
        ld_word("s2_w2", 18'h15555, 1'b1, 8'h01);
        #1;
        check("s2_state_idle", 32'(state), 32'd0);

        // Scenario 3: breakpoint at PC 3
        tick();
        bp_en = 2'b01; bp_addr = 16'h0003;
        send_cmd(OP_RUN, 8'h00);
        #1;
        check("s3_state_run", 32'(state), 32'd2);
        check("s3_cpu_rst", 32'(cpu_rst), 32'd0);
        check("s3_en_first", 32'(cpu_en), 32'd1);
        check("s3_pc_first", 32'(pc), 32'd0);
        tick(); tick(); tick();
        #1;
        check("s3_pc_at_bp", 32'(pc), 32'd3);
        check("s3_en_blocked", 32'(cpu_en), 32'd0);
        tick();
        check("s3_state_halted", 32'(state), 32'd4);
        check("s3_cause_bp", 32'(halt_cause), 32'd2);
        check("s3_count", cycle_count, 32'd3);
        check("s3_pc_held", 32'(pc), 32'd3);

        // Scenario 4: resume past the breakpoint, then host HALT
        send_cmd(OP_RUN, 8'h00);
        #1;
        check("s4_state_run", 32'(state), 32'd2);
        check("s4_en_skip", 32'(cpu_en), 32'd1);
        tick();
        check("s4_pc_advanced", 32'(pc), 32'd4);
        tick();
        send_cmd(OP_HALT, 8'h00);
        #1;
        check("s4_state_halted", 32'(state), 32'd4);
        check("s4_cause_host", 32'(halt_cause), 32'd1);
        check("s4_pc", 32'(pc), 32'd6);
        check("s4_count", cycle_count, 32'd6);

        // Scenario 5: single steps, second one sitting on an enabled breakpoint
        send_cmd(OP_STEP, 8'h00);
        #1;
        check("s5_state_step", 32'(state), 32'd3);
        check("s5_en_step", 32'(cpu_en), 32'd1);
        tick();
        check("s5_state_halted", 32'(state), 32'd4);
        check("s5_cause_step", 32'(halt_cause), 32'd4);
        check("s5_count", cycle_count, 32'd7);
        check("s5_pc", 32'(pc), 32'd7);
        check("s5_cpu_rst_halted", 32'(cpu_rst), 32'd0);
        bp_en = 2'b11; bp_addr = {8'h07, 8'h03};
        #1;
        check("s5_en_halted", 32'(cpu_en), 32'd0);
        send_cmd(OP_STEP, 8'h00);
        #1;
        check("s5_en_step_on_bp", 32'(cpu_en), 32'd1);
        tick();
        check("s5_cause_step2", 32'(halt_cause), 32'd4);
        check("s5_count2", cycle_count, 32'd8);
        check("s5_pc2", 32'(pc), 32'd8);
        send_cmd(OP_RCPU, 8'h00);
        check("s5_rcpu_state", 32'(state), 32'd0);
        check("s5_rcpu_count", cycle_count, 32'd0);
        check("s5_rcpu_cause", 32'(halt_cause), 32'd0);
        check("s5_rcpu_cpu_rst", 32'(cpu_rst), 32'd1);
        bp_en = 2'b00;
        tick();
        check("s5_pc_cleared", 32'(pc), 32'd0);

        // Scenario 6: watchdog at 5 enabled cycles
        cycle_limit = 32'd5;
        send_cmd(OP_RUN, 8'h00);
        tick(); tick(); tick(); tick();
        check("s6_state_still_run", 32'(state), 32'd2);
        check("s6_count_4", cycle_count, 32'd4);
        tick();
        check("s6_state_halted", 32'(state), 32'd4);
        check("s6_cause_limit", 32'(halt_cause), 32'd3);
        check("s6_count_5", cycle_count, 32'd5);
        check("s6_pc", 32'(pc), 32'd5);

        // Reset asserted while running
        send_cmd(OP_RCPU, 8'h00);
        cycle_limit = 32'd0;
        send_cmd(OP_RUN, 8'h00);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("s6_rst_state", 32'(state), 32'd0);
        check("s6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("s6_rst_count", cycle_count, 32'd0);
        check("s6_rst_cpu_en", 32'(cpu_en), 32'd0);
        check("s6_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // LIMIT outranks a HOST halt accepted on the same edge
        cycle_limit = 32'd3;
        send_cmd(OP_RUN, 8'h00);
        tick(); tick();
        send_cmd(OP_HALT, 8'h00);
        check("prio_state", 32'(state), 32'd4);
        check("prio_cause_limit", 32'(halt_cause), 32'd3);
        check("prio_count", cycle_count, 32'd3);
        check("prio_pc", 32'(pc), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Host-facing run-control and program-load block that sits between the bench/host and the `cpu` top.
- Replaces hierarchical pokes into instruction memory with a streamed load port that drives the instruction-memory write port.
- Gates CPU execution through a clock-enable and a held reset.
- Supports run, halt, single-step, PC breakpoints and a cycle-limit watchdog, and reports halt cause and a cycle count.

Parameters:
INSTR_W, 18, instruction word width.
ADDR_W, 8, instruction address / PC width.
NUM_BP, 2, number of PC breakpoint comparators (1..8).
CNT_W, 32, cycle counter and limit width.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command strobe.
cmd_ready  out  1  high in every state except LOAD.
cmd_op  in  3  0 NOP, 1 LOAD, 2 RUN, 3 HALT, 4 STEP, 5 RESET_CPU.
cmd_arg  in  ADDR_W  load base address (LOAD only).
ld_valid  in  1  load word valid.
ld_ready  out  1  high only in LOAD.
ld_data  in  INSTR_W  instruction word.
ld_last  in  1  marks the final word of a load.
imem_we  out  1  instruction-memory write enable.
imem_addr  out  ADDR_W  write address.
imem_wdata  out  INSTR_W  write data.
cpu_rst  out  1  holds the CPU in reset.
cpu_en  out  1  CPU advance enable; the CPU updates PC and registers only when high.
cpu_pc  in  ADDR_W  current CPU program counter.
bp_en  in  NUM_BP  per-breakpoint enable.
bp_addr  in  NUM_BP*ADDR_W  packed breakpoint addresses; slot i occupies [i*ADDR_W +: ADDR_W].
cycle_limit  in  CNT_W  watchdog limit; 0 disables it.
state  out  3  current FSM state.
halt_cause  out  3  0 NONE, 1 HOST, 2 BP, 3 LIMIT, 4 STEP.
cycle_count  out  CNT_W  count of cycles with cpu_en high.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, cpu_rst=1, cpu_en=0, imem_we=0, halt_cause=NONE, cycle_count=0, load pointer=0.
  - Reset asserted mid-LOAD or mid-RUN aborts immediately with the same result.
- Command handshake: a command is accepted on a clk edge with cmd_valid & cmd_ready. A command not legal in the current state is consumed and ignored; there is no state change.
- IDLE: cpu_rst=1.
  - LOAD → LOAD, pointer := cmd_arg.
  - RUN → RUN, cycle_count := 0, halt_cause := NONE.
  - STEP → STEP.
- LOAD: cpu_rst=1, ld_ready=1.
  - imem_we = ld_valid; imem_addr = pointer; imem_wdata = ld_data (combinational, same cycle).
  - The pointer increments per accepted word and wraps modulo 2^ADDR_W.
  - An accepted word with ld_last=1 is written, then state → IDLE.
  - No write occurs on cycles with ld_valid=0.
- RUN: cpu_rst=0.
  - bp_hit = OR over i of (bp_en[i] & cpu_pc==bp_addr[i]), combinational.
  - cpu_en = ~(bp_hit & ~resume_skip). resume_skip is set for the first RUN cycle after leaving HALTED, so the CPU can leave a breakpointed PC.
  - A blocked cycle (bp_hit without skip): cpu_en=0 that cycle, next state HALTED, cause BP.
  - Accepted HALT: next state HALTED, cause HOST. The cycle on which HALT is accepted still executes if cpu_en is high.
  - Watchdog: when cycle_limit≠0 and cycle_count+1==cycle_limit on an enabled cycle, next state HALTED, cause LIMIT.
  - Halt-cause priority when events coincide: BP > LIMIT > HOST.
- STEP: exactly one cycle with cpu_rst=0, cpu_en=1 and no breakpoint check; then HALTED, cause STEP.
- HALTED: cpu_rst=0, cpu_en=0.
  - RUN → RUN with resume_skip.
  - STEP → STEP.
  - LOAD → LOAD (cpu_rst=1, pointer := cmd_arg).
  - RESET_CPU → IDLE.
- RESET_CPU is accepted in any state except LOAD: → IDLE, cycle_count := 0, halt_cause := NONE.
- cycle_count increments on every cycle with cpu_en=1 and saturates at all-ones.
- All outputs except imem_* and cpu_en are registered; cpu_en and imem_* are combinational from state and inputs.

Decomposition:
- Package cpu_dbg_pkg holds:
  - state encoding: IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4;
  - cmd_op constants;
  - halt_cause constants.
- One sub-module, cpu_dbg_bp_match: parametrised NUM_BP/ADDR_W comparator array producing bp_hit and hit index.

Test Plan:
All scenarios use defaults, with a PC model that increments when cpu_en=1 and clears on cpu_rst.

1. LOAD arg=0, stream 0x01123 then 0x2120A with ld_last on the second → imem writes addr0=0x01123, addr1=0x2120A; state IDLE one cycle later; cpu_rst stays 1 throughout.
2. LOAD arg=0xFF, 3 words with ld_valid gaps between them → writes at 0xFF, 0x00, 0x01 only; imem_we=0 on gap cycles.
3. bp0=3 enabled, RUN from IDLE → cpu_en low on the cycle pc==3; state HALTED, cause BP=2, cycle_count=3.
4. From scenario 3, RUN → pc advances to 4 (skip honoured); HALT two cycles later → HALTED, cause HOST, pc=6.
5. From HALTED, STEP → exactly one cpu_en pulse, cause STEP, cycle_count +1; STEP with bp on the current PC still executes.
6. cycle_limit=5, RUN from IDLE → HALTED after 5 enabled cycles, cause LIMIT. Separately, reset asserted mid-RUN → next cycle IDLE, cpu_rst=1, cycle_count=0.
